rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_ctrl_pkg.sv | 22 ++
 rtl/rom_arbiter_if.sv | 37 +++
 rtl/rom_arbiter_rr_arb2.sv | 24 ++
 rtl/rom_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg
// Shared definitions for the ROM read arbiter: the controller state encoding
// and the default ROM address/data widths.
package rom_ctrl_pkg;

    // ROM geometry used as the default parameter values throughout.
    localparam int ROM_AW = 15;
    localparam int ROM_DW = 8;

    // Controller states. A transaction always visits IDLE -> READ -> DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the port encoded by a one-hot two-bit winner vector.
    function automatic logic onehot_to_port(input logic [1:0] onehot);
        return onehot[1];
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if
// Bundles the two requester ports, the shared read-data return and the
// synchronous ROM connection of the ROM arbiter.
//   master modport : the requesters and the ROM (drive req/addr/rom_data)
//   slave modport  : the arbiter (drives gnt/rvalid/rdata/busy/rom_addr/rom_oen)
interface rom_arbiter_if
    import rom_ctrl_pkg::*;
#(
    parameter int ADDR_W = ROM_AW,
    parameter int DATA_W = ROM_DW
);

    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_oen;
    logic [DATA_W-1:0] rom_data;

    modport master (
        output req0, req1, addr0, addr1, rom_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy, rom_addr, rom_oen
    );

    modport slave (
        input  req0, req1, addr0, addr1, rom_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy, rom_addr, rom_oen
    );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin winner selection, purely combinational.
//   req   : request vector, bit N = port N
//   last  : port that won the most recent grant (0 or 1)
//   grant : one-hot winner, all zero when nobody requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the port that did not win last
    // time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter
// Shares one synchronous ROM between two read ports. Each transaction takes
// three cycles (IDLE -> READ -> DONE): grant and ROM enable in the first,
// ROM access in the second, data capture in the third. All outputs are
// registered.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rom_arbiter_if slave modport (requests, grants, read data, ROM)
module rom_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int ADDR_W = ROM_AW,
    parameter int DATA_W = ROM_DW
) (
    input  logic         clk,
    input  logic         rst,
    rom_arbiter_if.slave bus
);

    state_t            state;
    logic              last_q;
    logic              owner_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              busy_q;
    logic              rom_oen_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        win;

    rr_arb2 u_arb (
        .req   ({bus.req1, bus.req0}),
        .last  (last_q),
        .grant (win)
    );

    // Main controller. Requests are only looked at in IDLE, so anything that
    // arrives during READ or DONE simply waits until the controller is idle.
    // The winner is latched as owner so the data return goes to the right
    // port even if the requests change meanwhile. Reset leaves last_q at 1
    // so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            busy_q     <= 1'b0;
            rom_oen_q  <= 1'b1;
            rom_addr_q <= '0;
            rdata_q    <= '0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win != 2'b00) begin
                        state      <= READ;
                        busy_q     <= 1'b1;
                        rom_oen_q  <= 1'b0;
                        gnt0_q     <= win[0];
                        gnt1_q     <= win[1];
                        owner_q    <= onehot_to_port(win);
                        last_q     <= onehot_to_port(win);
                        rom_addr_q <= win[1] ? bus.addr1 : bus.addr0;
                    end
                end
                READ: begin
                    state     <= DONE;
                    rom_oen_q <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    rdata_q   <= bus.rom_data;
                    rvalid0_q <= ~owner_q;
                    rvalid1_q <= owner_q;
                end
                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    rom_oen_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_oen  = rom_oen_q;

endmodule
